// File: rtl/mvu_pe_binary_acc.sv
// mvu_pe_binary_acc: consumer side of the binary SIMD multiplier lanes in a PE.
//
// Each accepted beat carries SIMD signed lane products.
// - Stage 1 registers the sign-extended lane sum together with first/last flags.
// - Stage 2 folds SF beats into one accumulator word and pushes the finished word
//   into a DEPTH-entry first-word-fall-through output FIFO.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_v / in_rdy     input beat handshake
//   in_prod           SIMD lane products, lane k at [k*TDstI +: TDstI]
//   out_v / out_rdy   output word handshake
//   out_acc           accumulated word (head of the output FIFO)
//   busy              partial group, in-flight beat or buffered result outstanding
//
// Build option:
//   MVAU_ACC_SAT_EN   when defined, the stage-2 add saturates to the signed TO range.
//                     Once a group saturates it stays clamped until the group ends.
//                     When undefined, the add wraps modulo 2^TO.

module mvu_pe_binary_acc #(
    parameter int unsigned SIMD  = 4,
    parameter int unsigned TDstI = 4,
    parameter int unsigned TO    = 16,
    parameter int unsigned SF    = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_v,
    output logic                  in_rdy,
    input  logic [SIMD*TDstI-1:0] in_prod,
    output logic                  out_v,
    input  logic                  out_rdy,
    output logic [TO-1:0]         out_acc,
    output logic                  busy
);

    localparam int unsigned CntW = (SF > 1) ? $clog2(SF) : 1;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic            accept;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            beat_last;
    logic            beat_first;
    logic [TO-1:0]   lane_sum;

    logic            s1_v_q;
    logic            s1_last_q;
    logic            s1_first_q;
    logic [TO-1:0]   s1_sum_q;

    logic [TO-1:0]   acc_q, acc_d;
    logic [TO-1:0]   base;

    logic [TO-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [OccW-1:0] occ_q, occ_d;
    logic [OccW:0]   pending;
    logic            push, pop;

    // ---------------------------------------------------------------
    // Input handshake and beat counter
    // ---------------------------------------------------------------
    // Every beat is gated, not only last beats. The count includes results
    // already buffered plus a finished group still sitting in stage 1. That
    // keeps the FIFO from ever being pushed while full.
    assign pending = {1'b0, occ_q} + (OccW + 1)'(s1_v_q & s1_last_q);
    assign in_rdy  = rst_n & (pending < (OccW + 1)'(DEPTH));
    assign accept  = in_v & in_rdy;

    assign beat_last  = (cnt_q == CntW'(SF - 1));
    assign beat_first = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = beat_last ? '0 : cnt_q + 1'b1;
        end
    end

    // Sign-extend each lane to TO bits before summing.
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < int'(SIMD); k++) begin
            lane_sum = lane_sum + {{(TO - TDstI){in_prod[k*TDstI + TDstI - 1]}},
                                   in_prod[k*TDstI +: TDstI]};
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: registered lane reduction
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            s1_v_q     <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_first_q <= 1'b0;
            s1_sum_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            s1_v_q <= accept;
            if (accept) begin
                s1_last_q  <= beat_last;
                s1_first_q <= beat_first;
                s1_sum_q   <= lane_sum;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: accumulator
    // ---------------------------------------------------------------
    // The first beat of a group starts from zero, so no separate clear is needed.
    assign base = s1_first_q ? '0 : acc_q;

`ifdef MVAU_ACC_SAT_EN
    localparam logic [TO-1:0] MaxVal = {1'b0, {(TO - 1){1'b1}}};
    localparam logic [TO-1:0] MinVal = {1'b1, {(TO - 1){1'b0}}};

    logic        sat_q, sat_d;
    logic [TO:0] wide;
    logic        ovf;

    assign wide = {base[TO-1], base} + {s1_sum_q[TO-1], s1_sum_q};
    assign ovf  = wide[TO] != wide[TO-1];

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (s1_v_q) begin
            if (!s1_first_q && sat_q) begin
                // Clamped earlier in this group: hold the limit.
                acc_d = acc_q;
                sat_d = 1'b1;
            end else if (ovf) begin
                acc_d = wide[TO] ? MinVal : MaxVal;
                sat_d = 1'b1;
            end else begin
                acc_d = wide[TO-1:0];
                sat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`else
    always_comb begin
        acc_d = acc_q;
        if (s1_v_q) begin
            acc_d = base + s1_sum_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // ---------------------------------------------------------------
    // Output FIFO (first-word-fall-through)
    // ---------------------------------------------------------------
    // A finished group is written straight from the stage-2 adder output.
    // The result therefore becomes visible two cycles after the last beat.
    assign push = s1_v_q & s1_last_q;
    assign pop  = out_v & out_rdy;

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push && pop) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            occ_q <= occ_d;
            if (push) begin
                mem_q[wr_ptr_q] <= acc_d;
                wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

    assign out_v   = (occ_q != '0);
    assign out_acc = out_v ? mem_q[rd_ptr_q] : '0;
    assign busy    = (cnt_q != '0) | s1_v_q | (occ_q != '0);

endmodule

// File: tb/tb_mvu_pe_binary_acc.sv
// Directed, table-driven bench for mvu_pe_binary_acc.
//
// A second instance with a deliberately narrow 6-bit accumulator forces
// overflow. It checks wrap behaviour by default and sticky saturation when
// MVAU_ACC_SAT_EN is defined.

module tb_mvu_pe_binary_acc;

    localparam int SIMD  = 4;
    localparam int TDstI = 4;
    localparam int TO    = 16;
    localparam int SF    = 3;
    localparam int DEPTH = 2;
    localparam int TO_S  = 6;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_v;
    logic                  in_rdy;
    logic [SIMD*TDstI-1:0] in_prod;
    logic                  out_v;
    logic                  out_rdy;
    logic [TO-1:0]         out_acc;
    logic                  busy;

    logic                  s_in_v;
    logic                  s_in_rdy;
    logic [SIMD*TDstI-1:0] s_in_prod;
    logic                  s_out_v;
    logic                  s_out_rdy;
    logic [TO_S-1:0]       s_out_acc;
    logic                  s_busy;

    always #5 clk = ~clk;

    mvu_pe_binary_acc #(
        .SIMD  (SIMD),
        .TDstI (TDstI),
        .TO    (TO),
        .SF    (SF),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_v    (in_v),
        .in_rdy  (in_rdy),
        .in_prod (in_prod),
        .out_v   (out_v),
        .out_rdy (out_rdy),
        .out_acc (out_acc),
        .busy    (busy)
    );

    mvu_pe_binary_acc #(
        .SIMD  (SIMD),
        .TDstI (TDstI),
        .TO    (TO_S),
        .SF    (SF),
        .DEPTH (DEPTH)
    ) dut_s (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_v    (s_in_v),
        .in_rdy  (s_in_rdy),
        .in_prod (s_in_prod),
        .out_v   (s_out_v),
        .out_rdy (s_out_rdy),
        .out_acc (s_out_acc),
        .busy    (s_busy)
    );

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    logic [TO-1:0] got [$];

    // Collect every output transfer; inputs change only just after posedge.
    always @(negedge clk) begin
        if (out_v && out_rdy) got.push_back(out_acc);
    end

    typedef struct {
        string         name;
        logic [15:0]   beat [3];
        logic [TO-1:0] exp;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [15:0] pack(input int a, input int b, input int c, input int d);
        logic [31:0] la, lb, lc, ld;
        la = a;
        lb = b;
        lc = c;
        ld = d;
        return {ld[3:0], lc[3:0], lb[3:0], la[3:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [15:0] prod);
        int n;
        n = 0;
        in_prod = prod;
        in_v    = 1'b1;
        while (!in_rdy && n < 50) begin
            step();
            n++;
            stalls++;
        end
        if (!in_rdy) begin
            check("send_timeout", 32'(in_rdy), 32'd1);
            in_v = 1'b0;
        end else begin
            step();
            in_v = 1'b0;
        end
    endtask

    task automatic wait_out(input string name, input int cnt, input int bound);
        int n;
        n = 0;
        while (got.size() < cnt && n < bound) begin
            step();
            n++;
        end
        check(name, 32'(got.size()), 32'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [TO_S-1:0] exp_s;
        int              n;

        tbl[0] = '{name: "basic",  beat: '{pack(1, 1, 1, 1), pack(2, 0, 0, 0),
                                          pack(-1, -1, 0, 0)}, exp: 16'd4};
        tbl[1] = '{name: "ones",   beat: '{pack(1, 1, 1, 1), pack(1, 1, 1, 1),
                                          pack(1, 1, 1, 1)}, exp: 16'd12};
        tbl[2] = '{name: "neg8",   beat: '{pack(-8, -8, -8, -8), pack(-8, -8, -8, -8),
                                          pack(-8, -8, -8, -8)}, exp: 16'hFFA0};
        tbl[3] = '{name: "mixed1", beat: '{pack(7, -8, 3, -2), pack(5, 5, -3, 0),
                                          pack(-1, 2, 6, -4)}, exp: 16'd10};
        tbl[4] = '{name: "mixed2", beat: '{pack(-8, 7, -8, 7), pack(0, 0, 0, -1),
                                          pack(1, 1, 1, 1)}, exp: 16'd1};
        tbl[5] = '{name: "sevens", beat: '{pack(7, 7, 7, 7), pack(7, 7, 7, 7),
                                          pack(7, 7, 7, 7)}, exp: 16'd84};

        rst_n     = 1'b0;
        in_v      = 1'b0;
        in_prod   = '0;
        out_rdy   = 1'b0;
        s_in_v    = 1'b0;
        s_in_prod = '0;
        s_out_rdy = 1'b0;
        step();
        step();

        // Reset state
        check("rst_in_rdy", 32'(in_rdy), 32'd0);
        check("rst_out_v", 32'(out_v), 32'd0);
        check("rst_out_acc", 32'(out_acc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_rdy", 32'(in_rdy), 32'd1);

        // Basic group with exact latency
        out_rdy = 1'b1;
        got.delete();
        send(tbl[0].beat[0]);
        send(tbl[0].beat[1]);
        send(tbl[0].beat[2]);
        check("lat_t1_out_v", 32'(out_v), 32'd0);
        step();
        check("lat_t2_out_v", 32'(out_v), 32'd1);
        check("lat_t2_out_acc", 32'(out_acc), 32'd4);
        wait_out("basic_cnt", 1, 10);
        step();
        step();
        check("basic_idle_busy", 32'(busy), 32'd0);

        // Table of single groups
        for (int i = 0; i < 6; i++) begin
            got.delete();
            for (int b = 0; b < 3; b++) send(tbl[i].beat[b]);
            wait_out({tbl[i].name, "_cnt"}, 1, 20);
            step();
            step();
            check({tbl[i].name, "_single"}, 32'(got.size()), 32'd1);
            if (got.size() > 0) check(tbl[i].name, 32'(got[0]), 32'(tbl[i].exp));
        end

        // Back-to-back groups, no stalls expected
        got.delete();
        stalls = 0;
        for (int i = 0; i < 6; i++) send(pack(1, 1, 1, 1));
        wait_out("b2b_cnt", 2, 20);
        check("b2b_stalls", 32'(stalls), 32'd0);
        if (got.size() >= 2) begin
            check("b2b_res0", 32'(got[0]), 32'd12);
            check("b2b_res1", 32'(got[1]), 32'd12);
        end

        // Backpressure: FIFO fills with two results, then input stalls
        step();
        step();
        got.delete();
        out_rdy = 1'b0;
        for (int i = 0; i < 6; i++) send(pack(7, 7, 7, 7));
        check("bp_in_rdy_low", 32'(in_rdy), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        in_prod = pack(7, 7, 7, 7);
        in_v    = 1'b1;
        n       = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (in_rdy) n++;
        end
        check("bp_held_rdy", 32'(n), 32'd0);
        check("bp_hold_out_v", 32'(out_v), 32'd1);
        check("bp_hold_out_acc", 32'(out_acc), 32'd84);
        check("bp_no_pop", 32'(got.size()), 32'd0);
        out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) send(pack(7, 7, 7, 7));
        wait_out("bp_cnt", 4, 40);
        step();
        step();
        check("bp_total", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            check($sformatf("bp_res%0d", i), 32'(got[i]), 32'd84);
        end

        // Reset mid-group discards the partial sum
        got.delete();
        send(pack(1, 1, 1, 1));
        send(pack(1, 1, 1, 1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_rdy", 32'(in_rdy), 32'd1);
        check("mid_no_out", 32'(got.size()), 32'd0);
        for (int i = 0; i < 3; i++) send(pack(1, 1, 1, 1));
        wait_out("mid_cnt", 1, 10);
        if (got.size() > 0) check("mid_result", 32'(got[0]), 32'd12);

        // Narrow accumulator: 28, 28 overflow, then -32
`ifdef MVAU_ACC_SAT_EN
        exp_s = 6'h1F;
`else
        exp_s = 6'h18;
`endif
        s_out_rdy = 1'b1;
        check("s_in_rdy", 32'(s_in_rdy), 32'd1);
        s_in_v    = 1'b1;
        s_in_prod = pack(7, 7, 7, 7);
        step();
        s_in_prod = pack(7, 7, 7, 7);
        step();
        s_in_prod = pack(-8, -8, -8, -8);
        step();
        s_in_v = 1'b0;
        n = 0;
        while (!s_out_v && n < 10) begin
            step();
            n++;
        end
        check("s_out_v", 32'(s_out_v), 32'd1);
        check("s_out_acc", 32'(s_out_acc), 32'(exp_s));

        step();
        step();
        check("final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
